// File: rtl/if_prefetch_stage_pkg.sv
// Shared constants for the instruction-fetch prefetch stage.
package if_prefetch_stage_pkg;
  localparam int WORD_LEN_DEF = 32;
  localparam int PC_INC_DEF   = 4;
  localparam int RESET_PC_DEF = 0;
  localparam logic [WORD_LEN_DEF-1:0] NOP = '0;
endpackage

// File: rtl/if_prefetch_stage_if.sv
// Fetch request/response bus between the prefetch stage (master) and instruction memory (slave).
interface if_prefetch_stage_if
  import if_prefetch_stage_pkg::*;
#(
  parameter int WORD_LEN = WORD_LEN_DEF
) ();
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [WORD_LEN-1:0] mem_req_addr;
  logic                mem_resp_valid;
  logic [WORD_LEN-1:0] mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/if_prefetch_stage_sync_fifo.sv
// Generic synchronous FIFO, head visible combinationally; flush beats push/pop.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo
  import if_prefetch_stage_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction prefetch: keeps up to DEPTH fetches buffered or in flight, discards responses
// overtaken by a redirect; head visible same cycle, held while freeze=1.
module if_prefetch_stage
  import if_prefetch_stage_pkg::*;
#(
  parameter int                  WORD_LEN = WORD_LEN_DEF,
  parameter int                  DEPTH    = 4,
  parameter logic [WORD_LEN-1:0] RESET_PC = WORD_LEN'(RESET_PC_DEF),
  parameter logic [WORD_LEN-1:0] PC_INC   = WORD_LEN'(PC_INC_DEF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                Branch_taken,
  input  logic [WORD_LEN-1:0] BranchAddr,
  if_prefetch_stage_if.master mem,
  output logic                inst_valid,
  output logic [WORD_LEN-1:0] PC,
  output logic [WORD_LEN-1:0] Instruction
);
  localparam int CW = $clog2(DEPTH+1);

  logic [WORD_LEN-1:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]         pend_q, pend_d, drop_q, drop_d;
  logic [CW-1:0]         fifo_cnt;
  logic [CW:0]           occ;
  logic                  fifo_full, fifo_empty;
  logic [2*WORD_LEN-1:0] head;
  logic                  req_fire, resp_fire, push, pop;

  // Buffered plus in-flight (including doomed) fetches bound the issue window.
  assign occ               = {1'b0, fifo_cnt} + {1'b0, pend_q};
  assign mem.mem_req_valid = rst && !Branch_taken && (occ < (CW+1)'(DEPTH));
  assign mem.mem_req_addr  = fetch_pc_q;

  assign req_fire   = mem.mem_req_valid && mem.mem_req_ready;
  assign resp_fire  = mem.mem_resp_valid && (pend_q != '0);
  assign inst_valid = !fifo_empty;
  assign pop        = inst_valid && !freeze && !Branch_taken;
  assign push       = resp_fire && (drop_q == '0) && !Branch_taken && (!fifo_full || pop);

  assign PC          = inst_valid ? head[2*WORD_LEN-1:WORD_LEN] + PC_INC : '0;
  assign Instruction = inst_valid ? head[WORD_LEN-1:0] : WORD_LEN'(NOP);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    if (Branch_taken) begin
      fetch_pc_d = BranchAddr;
      resp_pc_d  = BranchAddr;
      // Everything still in flight after this edge belongs to the old path.
      pend_d     = pend_q - CW'(resp_fire);
      drop_d     = pend_q - CW'(resp_fire);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_INC;
      if (push)     resp_pc_d  = resp_pc_q + PC_INC;
      if (resp_fire && (drop_q != '0)) drop_d = drop_q - CW'(1);
      pend_d = pend_q + CW'(req_fire) - CW'(resp_fire);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      pend_q     <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH (2*WORD_LEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (Branch_taken),
    .din   ({resp_pc_q, mem.mem_resp_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: queue-based reference model plus a latency-randomising memory.
module tb_if_prefetch_stage;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze, br;
  logic [31:0] br_addr;
  logic        iv;
  logic [31:0] pc_o, ins_o;
  logic        freeze16, br16, iv16;
  logic [15:0] ba16, pc16, ins16;

  always #5 clk = ~clk;

  if_prefetch_stage_if #(.WORD_LEN(32)) m32 ();
  if_prefetch_stage_if #(.WORD_LEN(16)) m16 ();

  if_prefetch_stage #(.WORD_LEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .Branch_taken(br), .BranchAddr(br_addr),
    .mem(m32), .inst_valid(iv), .PC(pc_o), .Instruction(ins_o)
  );

  if_prefetch_stage #(.WORD_LEN(16), .DEPTH(DEPTH)) dut16 (
    .clk(clk), .rst(rst), .freeze(freeze16), .Branch_taken(br16), .BranchAddr(ba16),
    .mem(m16), .inst_valid(iv16), .PC(pc16), .Instruction(ins16)
  );

  // Fixed one-cycle memory for the narrow instance.
  assign m16.mem_req_ready = 1'b1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m16.mem_resp_valid <= 1'b0;
      m16.mem_resp_data  <= '0;
    end else begin
      m16.mem_resp_valid <= m16.mem_req_valid && m16.mem_req_ready;
      m16.mem_resp_data  <= m16.mem_req_addr ^ 16'h5A5A;
    end
  end

  int compared   = 0;
  int mismatched = 0;

  // Reference state: what the stage should hold, kept as plain queues and counts.
  logic [31:0] m_q [$];
  int          m_pend, m_drop;
  logic [31:0] m_fetch, m_resp;
  logic [31:0] mq_addr [$];
  int          mq_due [$];
  int          cyc = 0;
  int          req_cnt;
  bit          det, bogus;
  int          lat_extra;
  logic        obs_rv, obs_iv;
  logic [31:0] obs_addr, obs_pc, obs_ins;

  function automatic logic [31:0] mfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    freeze = 1'b0; br = 1'b0; br_addr = '0;
    br16 = 1'b0; ba16 = '0;
    m32.mem_req_ready = 1'b1; m32.mem_resp_valid = 1'b0; m32.mem_resp_data = '0;
    m_q.delete(); mq_addr.delete(); mq_due.delete();
    m_pend = 0; m_drop = 0; m_fetch = '0; m_resp = '0; req_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(m32.mem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(iv), 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_instruction", ins_o, 32'd0);
    rst = 1'b1;
  endtask

  // One clock: drive at edge+1, check at edge+3, then advance model past the edge.
  task automatic step(input logic f, input logic b, input logic [31:0] ba);
    logic rdy, sf, exp_rv, mf;
    freeze = f; br = b; br_addr = ba;
    rdy = det ? 1'b1 : ($urandom_range(99) < 70);
    m32.mem_req_ready = rdy;
    sf = (mq_addr.size() > 0) && (mq_due[0] <= cyc) && (det || $urandom_range(3) != 0);
    if (sf) begin
      m32.mem_resp_valid = 1'b1;
      m32.mem_resp_data  = mfn(mq_addr[0]);
    end else begin
      m32.mem_resp_valid = bogus;
      m32.mem_resp_data  = $urandom;
    end
    #2;
    exp_rv   = !b && (m_q.size() + m_pend < DEPTH);
    obs_rv   = m32.mem_req_valid;
    obs_addr = m32.mem_req_addr;
    obs_iv   = iv;
    obs_pc   = pc_o;
    obs_ins  = ins_o;
    chk("req_valid", 32'(obs_rv), 32'(exp_rv));
    if (exp_rv) chk("req_addr", obs_addr, m_fetch);
    chk("inst_valid", 32'(obs_iv), 32'(m_q.size() != 0));
    chk("pc", obs_pc, (m_q.size() != 0) ? m_q[0] + 32'd4 : 32'd0);
    chk("instruction", obs_ins, (m_q.size() != 0) ? mfn(m_q[0]) : 32'd0);
    mf = obs_rv && rdy;
    if (mf) req_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (sf) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (mf) begin
      mq_addr.push_back(obs_addr);
      mq_due.push_back(cyc + (det ? lat_extra : int'($urandom_range(2))));
    end
    if (b) begin
      m_q.delete();
      m_pend  = m_pend - (sf ? 1 : 0);
      m_drop  = m_pend;
      m_fetch = ba;
      m_resp  = ba;
    end else begin
      if (m_q.size() > 0 && !f) void'(m_q.pop_front());
      if (sf && m_pend > 0) begin
        m_pend--;
        if (m_drop > 0) m_drop--;
        else begin
          m_q.push_back(m_resp);
          m_resp += 32'd4;
        end
      end
      if (exp_rv && rdy) begin
        m_pend++;
        m_fetch += 32'd4;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    freeze16 = 1'b0;
    det = 1'b1; bogus = 1'b0; lat_extra = 0;
    do_reset();

    // 16-bit instance: redirect to the top of the address space and wrap.
    br16 = 1'b1; ba16 = 16'hFFFC;
    #2 chk("w16_branch_noreq", 32'(m16.mem_req_valid), 32'd0);
    @(posedge clk); #1 br16 = 1'b0;
    #2 chk("w16_req_valid", 32'(m16.mem_req_valid), 32'd1);
    chk("w16_addr0", 32'(m16.mem_req_addr), 32'h0000_FFFC);
    @(posedge clk); #3 chk("w16_addr1", 32'(m16.mem_req_addr), 32'h0000_0000);
    @(posedge clk); #3 chk("w16_iv", 32'(iv16), 32'd1);
    chk("w16_pc0", 32'(pc16), 32'h0000_0000);
    chk("w16_ins0", 32'(ins16), 32'h0000_A5A6);
    @(posedge clk); #3 chk("w16_pc1", 32'(pc16), 32'h0000_0004);
    @(posedge clk); #1;

    // Sequential fetch from reset; first step also carries a stray response.
    do_reset();
    bogus = 1'b1;
    step(1'b0, 1'b0, '0);
    bogus = 1'b0;
    chk("seq_addr0", obs_addr, 32'h0);
    step(1'b0, 1'b0, '0);
    chk("seq_addr1", obs_addr, 32'h4);
    chk("seq_iv_c2", 32'(obs_iv), 32'd0);
    step(1'b0, 1'b0, '0);
    chk("seq_iv_c3", 32'(obs_iv), 32'd1);
    chk("seq_pc_c3", obs_pc, 32'h4);
    step(1'b0, 1'b0, '0);
    chk("seq_pc_c4", obs_pc, 32'h8);
    step(1'b0, 1'b0, '0);
    chk("seq_pc_c5", obs_pc, 32'hC);

    // Freeze from cycle 3: window fills and stops.
    do_reset();
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
    chk("frz_req_total", 32'(req_cnt), 32'd4);
    chk("frz_req_valid", 32'(obs_rv), 32'd0);
    chk("frz_head_pc", obs_pc, 32'h4);
    step(1'b0, 1'b0, '0);
    chk("frz_release_pc", obs_pc, 32'h4);
    step(1'b0, 1'b0, '0);
    chk("frz_next_pc", obs_pc, 32'h8);

    // Redirect with two fetches in flight.
    do_reset();
    lat_extra = 2;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h100);
    step(1'b0, 1'b0, '0);
    chk("br2_req_valid", 32'(obs_rv), 32'd1);
    chk("br2_req_addr", obs_addr, 32'h100);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, '0);
      if (obs_iv) break;
    end
    chk("br2_first_iv", 32'(obs_iv), 32'd1);
    chk("br2_first_pc", obs_pc, 32'h104);

    // Redirect coinciding with a response.
    do_reset();
    lat_extra = 0;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h200);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, '0);
      if (obs_iv) break;
    end
    chk("brr_first_iv", 32'(obs_iv), 32'd1);
    chk("brr_first_pc", obs_pc, 32'h204);
    chk("brr_first_ins", obs_ins, mfn(32'h200));

    // Randomised traffic with a reset in the middle.
    do_reset();
    det = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      step($urandom_range(9) < 3, $urandom_range(19) == 0, $urandom & 32'hFFFF_FFFC);
    end

    // Asynchronous reset with a full, frozen buffer.
    det = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
    chk("full_iv", 32'(obs_iv), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_req_valid", 32'(m32.mem_req_valid), 32'd0);
    chk("arst_inst_valid", 32'(iv), 32'd0);
    chk("arst_pc", pc_o, 32'd0);
    chk("arst_instruction", ins_o, 32'd0);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
